dcache_wt: RTL and testbench
============================

# dcache_wt

Write-through, no-write-allocate, N-way set-associative data cache between the LSUs and the data memory controller. It generalises the earlier single-block dcache: set count, ways, address/data width and consumer count are parameters. Consumers are arbitrated round-robin, and it has true hit/miss handling with line fill and per-set round-robin replacement. One request is serviced at a time over a single memory-side channel.

## Interface
Parameters:
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data word width; one word per line
- NUM_CONSUMERS, 4, number of LSUs served
- NUM_SETS, 4, sets; power of two, ≥2
- NUM_WAYS, 2, associativity; power of two, ≥1

Ports (arrays are unpacked, indexed per consumer):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- consumer_read_valid  in  NUM_CONSUMERS  read request
- consumer_read_address  in  ADDR_BITS×NUM_CONSUMERS  read address
- consumer_read_ready  out  NUM_CONSUMERS  read data valid
- consumer_read_data  out  DATA_BITS×NUM_CONSUMERS  read data
- consumer_write_valid  in  NUM_CONSUMERS  write request
- consumer_write_address  in  ADDR_BITS×NUM_CONSUMERS  write address
- consumer_write_data  in  DATA_BITS×NUM_CONSUMERS  write data
- consumer_write_ready  out  NUM_CONSUMERS  write done
- mem_read_valid  out  1  fill request
- mem_read_address  out  ADDR_BITS  fill address
- mem_read_ready  in  1  fill data valid
- mem_read_data  in  DATA_BITS  fill data
- mem_write_valid  out  1  write-through request
- mem_write_address  out  ADDR_BITS  write-through address
- mem_write_data  out  DATA_BITS  write-through data
- mem_write_ready  in  1  write accepted

## Operation
- Address split: set = addr[log2(NUM_SETS)-1:0]; tag = the remaining upper bits.
- State machine states: IDLE, LOOKUP, MEM_READ, MEM_WRITE, RELAY.
- IDLE:
  - Scan consumers starting at rr_ptr, wrapping; the first consumer with any valid request wins.
  - If a consumer asserts both read and write valid, read wins.
  - Latch consumer id, op, address and write data; go to LOOKUP.
- LOOKUP (tag compare across all ways of the set):
  - Read hit: drive consumer_read_data[id] from the hitting way, set consumer_read_ready[id]; go to RELAY.
  - Read miss: assert mem_read_valid with the latched address; go to MEM_READ.
  - Write, hit or miss: update the hitting way's data if hit (no allocation on miss); assert mem_write_valid with the latched address and data; go to MEM_WRITE.
- MEM_READ: when mem_read_ready is 1:
  - Drop mem_read_valid.
  - Install mem_read_data and the tag into victim way victim_ptr[set], and set its valid bit.
  - Advance victim_ptr[set] mod NUM_WAYS.
  - Drive read data/ready to the consumer; go to RELAY.
- MEM_WRITE: when mem_write_ready is 1, drop mem_write_valid, set consumer_write_ready[id]; go to RELAY.
- RELAY:
  - Hold the ready until the consumer's corresponding valid is 0.
  - Then clear the ready, set rr_ptr = id+1 (wrap), and go to IDLE.
- Victim selection: the first invalid way of the set, else victim_ptr[set].
- Memory ready inputs are ignored outside MEM_READ/MEM_WRITE.

## Timing
- All outputs are registered.
- Reset values:
  - All valid bits and victim_ptr = 0; rr_ptr = 0; state = IDLE.
  - All consumer readies, consumer_read_data, and the mem valid/address/data outputs = 0.
- Request sampled in IDLE at cycle 0 → LOOKUP at cycle 1.
- Read hit: ready/data visible at cycle 2.
- Miss: mem_read_valid visible at cycle 2. If mem_read_ready is first sampled high in cycle k, consumer_read_ready is visible at k+1 and mem_read_valid is low at k+1.
- Write: mem_write_valid visible at cycle 2; consumer_write_ready is visible one cycle after mem_write_ready is sampled.
- Release: the consumer drops valid at cycle r → ready is low at r+1; the next request can be accepted in IDLE at r+1 (sampled there, LOOKUP at r+2).
- Reset mid-miss: all state is cleared the next edge and the cache restarts cold. The memory controller must tolerate mem_*_valid dropping.
- A write that hits a line being relayed cannot occur, since there is one request in flight at a time.

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_count and miss_count, each 16 bits, reset to 0.
  - Each increments once per LOOKUP: a read hit or write hit counts as a hit; a read miss or write miss counts as a miss.
  - Both counters saturate at 0xFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Cold read miss: consumer 0 reads addr 0x12, memory returns 0xA5 after 3 cycles → exactly one fill request, consumer_read_data[0]=0xA5. A repeat read of 0x12 hits, shows ready at cycle 2, and issues no mem_read_valid.
- Write-through hit: after filling 0x12, write 0x3C to 0x12 → mem_write 0x12/0x3C issued; a later read of 0x12 returns 0x3C with no fill. A write to uncached 0x40 does not allocate: the next read of 0x40 misses.
- Replacement (NUM_WAYS=2, NUM_SETS=4): read 0x01, 0x05, 0x09 (same set) → the third fill evicts 0x01. Reading 0x05 hits; reading 0x01 misses.
- Arbitration: consumers 0, 1 and 3 request simultaneously → service order is 0, 1, 3. A re-asserted request from consumer 0 is served after 3.
- Read+write from one consumer in the same cycle → the read is serviced first.
- Reset during MEM_READ → all outputs are 0 the next cycle, and a prior hit address now misses.
- With DCACHE_STATS_EN: the 2-miss/1-hit sequence gives hit_count=1, miss_count=2.

Source files
------------

// File: rtl/dcache_wt.sv
// Write-through, no-write-allocate, N-way set-associative data cache.
// Optional DCACHE_STATS_EN adds saturating 16-bit hit/miss counters.
module dcache_wt #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_SETS      = 4,
  parameter int NUM_WAYS      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 consumer_read_valid    [NUM_CONSUMERS],
  input  logic [ADDR_BITS-1:0] consumer_read_address  [NUM_CONSUMERS],
  output logic                 consumer_read_ready    [NUM_CONSUMERS],
  output logic [DATA_BITS-1:0] consumer_read_data     [NUM_CONSUMERS],
  input  logic                 consumer_write_valid   [NUM_CONSUMERS],
  input  logic [ADDR_BITS-1:0] consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0] consumer_write_data    [NUM_CONSUMERS],
  output logic                 consumer_write_ready   [NUM_CONSUMERS],
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS = ADDR_BITS - SET_BITS;
  localparam int ID_BITS  = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_READ, MEM_WRITE, RELAY
  } state_t;

  state_t               state_q, state_d;
  logic [ID_BITS-1:0]   id_q, id_d;
  logic [ID_BITS-1:0]   rr_q, rr_d;
  logic                 op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;

  logic                 valid_q [NUM_SETS][NUM_WAYS];
  logic                 valid_d [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0]  tag_d   [NUM_SETS][NUM_WAYS];
  logic [DATA_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [DATA_BITS-1:0] data_d  [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0]  vptr_q  [NUM_SETS];
  logic [WAY_BITS-1:0]  vptr_d  [NUM_SETS];

  logic                 crr_q [NUM_CONSUMERS];
  logic                 crr_d [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] crd_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] crd_d [NUM_CONSUMERS];
  logic                 cwr_q [NUM_CONSUMERS];
  logic                 cwr_d [NUM_CONSUMERS];
  logic                 mrv_q, mrv_d;
  logic [ADDR_BITS-1:0] mra_q, mra_d;
  logic                 mwv_q, mwv_d;
  logic [ADDR_BITS-1:0] mwa_q, mwa_d;
  logic [DATA_BITS-1:0] mwd_q, mwd_d;

  logic                 arb_found;
  logic [ID_BITS-1:0]   arb_id;
  logic [SET_BITS-1:0]  set_idx;
  logic [TAG_BITS-1:0]  tag_in;
  logic                 hit;
  logic [WAY_BITS-1:0]  hit_way;
  logic [WAY_BITS-1:0]  victim;

  assign set_idx = addr_q[SET_BITS-1:0];
  assign tag_in  = addr_q[ADDR_BITS-1:SET_BITS];

  // Round-robin scan starting at rr_q
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      int j;
      j = (int'(rr_q) + i) % NUM_CONSUMERS;
      if (!arb_found &&
          (consumer_read_valid[j] || consumer_write_valid[j])) begin
        arb_found = 1'b1;
        arb_id    = ID_BITS'(j);
      end
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = vptr_q[set_idx];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
    // Lowest-numbered invalid way takes precedence over the pointer
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) victim = WAY_BITS'(w);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    vptr_d  = vptr_q;
    crr_d   = crr_q;
    crd_d   = crd_q;
    cwr_d   = cwr_q;
    mrv_d   = mrv_q;
    mra_d   = mra_q;
    mwv_d   = mwv_q;
    mwa_d   = mwa_q;
    mwd_d   = mwd_q;
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          id_d    = arb_id;
          op_wr_d = !consumer_read_valid[arb_id];
          addr_d  = consumer_read_valid[arb_id] ?
                    consumer_read_address[arb_id] :
                    consumer_write_address[arb_id];
          wdata_d = consumer_write_data[arb_id];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!op_wr_q) begin
          if (hit) begin
            crd_d[id_q] = data_q[set_idx][hit_way];
            crr_d[id_q] = 1'b1;
            state_d     = RELAY;
          end else begin
            mrv_d   = 1'b1;
            mra_d   = addr_q;
            state_d = MEM_READ;
          end
        end else begin
          if (hit) data_d[set_idx][hit_way] = wdata_q;
          mwv_d   = 1'b1;
          mwa_d   = addr_q;
          mwd_d   = wdata_q;
          state_d = MEM_WRITE;
        end
      end
      MEM_READ: begin
        if (mem_read_ready) begin
          mrv_d                   = 1'b0;
          valid_d[set_idx][victim] = 1'b1;
          tag_d[set_idx][victim]   = tag_in;
          data_d[set_idx][victim]  = mem_read_data;
          vptr_d[set_idx] =
            (vptr_q[set_idx] == WAY_BITS'(NUM_WAYS - 1)) ?
            '0 : vptr_q[set_idx] + WAY_BITS'(1);
          crd_d[id_q] = mem_read_data;
          crr_d[id_q] = 1'b1;
          state_d     = RELAY;
        end
      end
      MEM_WRITE: begin
        if (mem_write_ready) begin
          mwv_d       = 1'b0;
          cwr_d[id_q] = 1'b1;
          state_d     = RELAY;
        end
      end
      RELAY: begin
        if (op_wr_q ? !consumer_write_valid[id_q]
                    : !consumer_read_valid[id_q]) begin
          crr_d[id_q] = 1'b0;
          cwr_d[id_q] = 1'b0;
          rr_d = (id_q == ID_BITS'(NUM_CONSUMERS - 1)) ?
                 '0 : id_q + ID_BITS'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      rr_q    <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= '{default: '0};
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
      vptr_q  <= '{default: '0};
      crr_q   <= '{default: '0};
      crd_q   <= '{default: '0};
      cwr_q   <= '{default: '0};
      mrv_q   <= 1'b0;
      mra_q   <= '0;
      mwv_q   <= 1'b0;
      mwa_q   <= '0;
      mwd_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      vptr_q  <= vptr_d;
      crr_q   <= crr_d;
      crd_q   <= crd_d;
      cwr_q   <= cwr_d;
      mrv_q   <= mrv_d;
      mra_q   <= mra_d;
      mwv_q   <= mwv_d;
      mwa_q   <= mwa_d;
      mwd_q   <= mwd_d;
    end
  end

  assign consumer_read_ready  = crr_q;
  assign consumer_read_data   = crd_q;
  assign consumer_write_ready = cwr_q;
  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = mra_q;
  assign mem_write_valid      = mwv_q;
  assign mem_write_address    = mwa_q;
  assign mem_write_data       = mwd_q;

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: vector table, corner sequences,
// and randomized traffic against an address-level cache model.
module tb_dcache_wt;

  logic       clk = 1'b0;
  logic       reset;
  logic       c_rv  [4];
  logic [7:0] c_ra  [4];
  logic       c_rr  [4];
  logic [7:0] c_rd  [4];
  logic       c_wv  [4];
  logic [7:0] c_wa  [4];
  logic [7:0] c_wd  [4];
  logic       c_wr  [4];
  logic       mem_read_valid;
  logic [7:0] mem_read_address;
  logic       mem_read_ready;
  logic [7:0] mem_read_data;
  logic       mem_write_valid;
  logic [7:0] mem_write_address;
  logic [7:0] mem_write_data;
  logic       mem_write_ready;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  dcache_wt dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (c_rv),
    .consumer_read_address  (c_ra),
    .consumer_read_ready    (c_rr),
    .consumer_read_data     (c_rd),
    .consumer_write_valid   (c_wv),
    .consumer_write_address (c_wa),
    .consumer_write_data    (c_wd),
    .consumer_write_ready   (c_wr),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count              (hit_count),
    .miss_count             (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] iv(input int a);
    return (a == 8'h12) ? 8'hA5 : 8'((a * 13 + 7) & 255);
  endfunction

  // Memory controller model
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int mem_lat = 3;
  int fills = 0;
  int writes = 0;
  logic [7:0] last_wa, last_wd;

  initial begin
    int rcnt, wcnt;
    rcnt = 0;
    wcnt = 0;
    mem_read_ready  = 1'b0;
    mem_read_data   = 8'h00;
    mem_write_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        rcnt = 0;
        wcnt = 0;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
      end else begin
        if (mem_read_ready) mem_read_ready = 1'b0;
        else if (mem_read_valid) begin
          rcnt++;
          if (rcnt >= mem_lat) begin
            mem_read_data  = mem[mem_read_address];
            mem_read_ready = 1'b1;
            fills++;
            rcnt = 0;
          end
        end
        if (mem_write_ready) mem_write_ready = 1'b0;
        else if (mem_write_valid) begin
          wcnt++;
          if (wcnt >= mem_lat) begin
            mem[mem_write_address] = mem_write_data;
            last_wa = mem_write_address;
            last_wd = mem_write_data;
            mem_write_ready = 1'b1;
            writes++;
            wcnt = 0;
          end
        end
      end
    end
  end

  // Reference cache: which addresses live in each set's ways
  bit       m_valid [4][2];
  int       m_addr  [4][2];
  int       m_vptr  [4];
  int       exp_hits, exp_misses;

  task automatic m_reset();
    for (int s = 0; s < 4; s++) begin
      m_vptr[s] = 0;
      for (int w = 0; w < 2; w++) m_valid[s][w] = 0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  function automatic bit m_hit(input int a);
    for (int w = 0; w < 2; w++)
      if (m_valid[a % 4][w] && m_addr[a % 4][w] == a) return 1;
    return 0;
  endfunction

  task automatic m_fill(input int a);
    int s, way;
    s   = a % 4;
    way = m_vptr[s];
    for (int w = 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
    m_valid[s][way] = 1;
    m_addr[s][way]  = a;
    m_vptr[s]       = (m_vptr[s] + 1) % 2;
  endtask

  task automatic clr_inputs();
    for (int c = 0; c < 4; c++) begin
      c_rv[c] = 0; c_ra[c] = 0; c_wv[c] = 0; c_wa[c] = 0; c_wd[c] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  task automatic do_op(input int c, input bit wr, input logic [7:0] a,
                       input logic [7:0] d, input bit exp_hit,
                       input logic [7:0] exp_rd, input int lat);
    int f0, w0, cyc;
    bit done;
    mem_lat = lat;
    f0 = fills;
    w0 = writes;
    cyc = 0;
    done = 0;
    if (exp_hit) exp_hits++; else exp_misses++;
    if (wr) begin c_wv[c] = 1; c_wa[c] = a; c_wd[c] = d; end
    else begin c_rv[c] = 1; c_ra[c] = a; end
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      done = wr ? c_wr[c] : c_rr[c];
    end
    chk("op_timeout", 32'(done), 1);
    if (!wr) begin
      chk("rdata", c_rd[c], exp_rd);
      chk("fill_count", fills - f0, exp_hit ? 0 : 1);
      chk("read_latency", cyc, exp_hit ? 2 : 2 + lat);
      chk("mrv_dropped", 32'(mem_read_valid), 0);
    end else begin
      chk("wt_count", writes - w0, 1);
      chk("wt_addr", last_wa, a);
      chk("wt_data", last_wd, d);
      chk("write_latency", cyc, 2 + lat);
      chk("write_no_fill", fills - f0, 0);
    end
    c_rv[c] = 0;
    c_wv[c] = 0;
    @(posedge clk);
    #1;
    chk("release", 32'(wr ? c_wr[c] : c_rr[c]), 0);
  endtask

  task automatic run_op(input int c, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input bit exp_hit,
                        input logic [7:0] exp_rd, input int lat);
    do_op(c, wr, a, d, exp_hit, exp_rd, lat);
    if (wr) ref_mem[a] = d;
    else if (!m_hit(a)) m_fill(a);
  endtask

  typedef struct {
    int         c;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    bit         hit;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int order [$];
    int cyc;
    bit re0;
    int f0, w0;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = iv(i);
      ref_mem[i] = iv(i);
    end
    clr_inputs();
    do_reset();

    chk("rst_mem_valids", {31'd0, mem_read_valid | mem_write_valid}, 0);
    chk("rst_mem_addrs", {mem_read_address, mem_write_address,
                          mem_write_data}, 0);
    for (int c = 0; c < 4; c++)
      chk("rst_consumer", {c_rr[c], c_wr[c], c_rd[c]}, 0);

    tbl[0]  = '{0, 0, 8'h12, 8'h00, 0, 8'hA5};
    tbl[1]  = '{0, 0, 8'h12, 8'h00, 1, 8'hA5};
    tbl[2]  = '{1, 1, 8'h12, 8'h3C, 1, 8'h00};
    tbl[3]  = '{2, 0, 8'h12, 8'h00, 1, 8'h3C};
    tbl[4]  = '{3, 1, 8'h40, 8'h77, 0, 8'h00};
    tbl[5]  = '{0, 0, 8'h40, 8'h00, 0, 8'h77};
    tbl[6]  = '{1, 0, 8'h01, 8'h00, 0, iv(8'h01)};
    tbl[7]  = '{2, 0, 8'h05, 8'h00, 0, iv(8'h05)};
    tbl[8]  = '{3, 0, 8'h09, 8'h00, 0, iv(8'h09)};
    tbl[9]  = '{0, 0, 8'h05, 8'h00, 1, iv(8'h05)};
    tbl[10] = '{1, 0, 8'h01, 8'h00, 0, iv(8'h01)};
    tbl[11] = '{2, 0, 8'h09, 8'h00, 1, iv(8'h09)};
    for (int i = 0; i < 12; i++)
      run_op(tbl[i].c, tbl[i].wr, tbl[i].a, tbl[i].d,
             tbl[i].hit, tbl[i].rd, 3);
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, 32'(exp_hits));
    chk("miss_count", miss_count, 32'(exp_misses));
`endif

    // Read and write from one consumer together: read first
    mem_lat = 2;
    f0 = writes;
    c_rv[2] = 1; c_ra[2] = 8'h30;
    c_wv[2] = 1; c_wa[2] = 8'h31; c_wd[2] = 8'h99;
    cyc = 0;
    while (!(c_rr[2] || c_wr[2]) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("rw_read_first", {c_rr[2], c_wr[2]}, 2'b10);
    chk("rw_read_data", c_rd[2], ref_mem[8'h30]);
    chk("rw_no_write_yet", writes - f0, 0);
    if (!m_hit(8'h30)) m_fill(8'h30);
    c_rv[2] = 0;
    cyc = 0;
    while (!c_wr[2] && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("rw_write_done", 32'(c_wr[2]), 1);
    chk("rw_write_addr", last_wa, 8'h31);
    chk("rw_write_data", last_wd, 8'h99);
    ref_mem[8'h31] = 8'h99;
    c_wv[2] = 0;
    @(posedge clk); #1;

    // Reset in the middle of a fill
    run_op(0, 0, 8'h12, 8'h00, m_hit(8'h12), ref_mem[8'h12], 2);
    mem_lat = 10;
    c_rv[1] = 1; c_ra[1] = 8'h57;
    cyc = 0;
    while (!mem_read_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("midmiss_fill_req", 32'(mem_read_valid), 1);
    reset = 1'b1;
    c_rv[1] = 0;
    @(posedge clk); #1;
    chk("midmiss_rst_mem", {mem_read_valid, mem_write_valid,
                            mem_read_address, mem_write_address,
                            mem_write_data}, 0);
    for (int c = 0; c < 4; c++)
      chk("midmiss_rst_cons", {c_rr[c], c_wr[c], c_rd[c]}, 0);
    reset = 1'b0;
    m_reset();
    run_op(0, 0, 8'h12, 8'h00, 0, ref_mem[8'h12], 2);

    // Arbitration: 0,1,3 together, then 0 again
    do_reset();
    mem_lat = 1;
    c_rv[0] = 1; c_ra[0] = 8'h21;
    c_rv[1] = 1; c_ra[1] = 8'h22;
    c_rv[3] = 1; c_ra[3] = 8'h23;
    re0 = 0;
    cyc = 0;
    while (order.size() < 4 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      for (int c = 0; c < 4; c++) begin
        if (c_rv[c] && c_rr[c]) begin
          order.push_back(c);
          chk("arb_data", c_rd[c], ref_mem[c_ra[c]]);
          if (!m_hit(c_ra[c])) m_fill(c_ra[c]);
          c_rv[c] = 0;
        end
      end
      if (order.size() >= 1 && !re0 && !c_rr[0] && !c_rv[0]) begin
        c_rv[0] = 1; c_ra[0] = 8'h24; re0 = 1;
      end
    end
    chk("arb_count", order.size(), 4);
    while (order.size() < 4) order.push_back(-1);
    chk("arb_order0", order[0], 0);
    chk("arb_order1", order[1], 1);
    chk("arb_order2", order[2], 3);
    chk("arb_order3", order[3], 0);
    clr_inputs();
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    for (int n = 0; n < 120; n++) begin
      int c, lat;
      bit wr;
      logic [7:0] a, d;
      c   = $urandom_range(0, 3);
      wr  = ($urandom_range(0, 2) == 0);
      a   = 8'($urandom_range(0, 23));
      d   = 8'($urandom);
      lat = $urandom_range(1, 4);
      w0  = 0;
      run_op(c, wr, a, d, m_hit(a), ref_mem[a], lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1);
  end

endmodule
